// File: rtl/control_ajuste.sv
// control_ajuste: time/alarm setting sequencer for the alarm clock.
//
// Sits between the raw front-panel buttons and the hour/minute counters of the
// clock and the alarm. Each button is synchronized (2 FF) and debounced; the
// rising edge of a debounced level is a press. A mode FSM (NORMAL -> set clock
// -> set alarm -> NORMAL) routes hour/minute presses to one-cycle increment
// pulses for either the clock or the alarm counters. An inactivity timeout
// returns a setting mode to NORMAL.
//
// Optional feature, macro AUTO_REPETICION_EN:
//   defined   - holding hour/minute auto-repeats: first repeat HOLD_CYCLES after
//               the press pulse, then one every REPEAT_CYCLES.
//   undefined - hold counters are removed; one pulse per press.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   boton_modo     raw mode button (asynchronous, active-high)
//   boton_hora     raw hour button (asynchronous, active-high)
//   boton_minuto   raw minute button (asynchronous, active-high)
//   hora_reloj     1-cycle pulse: increment clock hour
//   minuto_reloj   1-cycle pulse: increment clock minute
//   hora_alarma    1-cycle pulse: increment alarm hour
//   minuto_alarma  1-cycle pulse: increment alarm minute
//   seleccion      1 while setting the alarm
//   ajustando      1 in either setting mode
//   pausa_segundos 1 while setting the clock (freezes/clears seconds)
//
// All outputs are registered.

module control_ajuste #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_modo,
  input  logic boton_hora,
  input  logic boton_minuto,
  output logic hora_reloj,
  output logic minuto_reloj,
  output logic hora_alarma,
  output logic minuto_alarma,
  output logic seleccion,
  output logic ajustando,
  output logic pausa_segundos
);

  // Button indices
  localparam int unsigned BtnModo   = 0;
  localparam int unsigned BtnHora   = 1;
  localparam int unsigned BtnMinuto = 2;

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DW-1:0] DbLim = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DbInc = DW'(1);
  localparam logic [TW-1:0] ToLim = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] ToMax = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] ToInc = TW'(1);

  typedef enum logic [1:0] {
    StNormal,
    StReloj,
    StAlarma
  } state_e;

  // ---------------------------------------------------------------------------
  // Input path: synchronizer + debouncer per button
  // ---------------------------------------------------------------------------
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d;
  logic [2:0]    deb_prev_q;
  logic [DW-1:0] db_cnt_q [3];
  logic [DW-1:0] db_cnt_d [3];
  logic [2:0]    press;

  assign raw = {boton_minuto, boton_hora, boton_modo};

  // The level flips on the cycle after the counter has recorded DEBOUNCE_CYCLES
  // consecutive mismatches; any matching cycle restarts the count.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbLim) begin
          deb_d[i]    = ~deb_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbInc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  // ---------------------------------------------------------------------------
  // Event qualification
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]    rep;     // auto-repeat events: [0] hora, [1] minuto
  logic          setting;
  logic          modo_ev, hora_ev, min_ev, accepted, timeout;

  assign setting  = (state_q != StNormal);
  assign modo_ev  = press[BtnModo];
  assign hora_ev  = setting & (press[BtnHora] | rep[0]);
  assign min_ev   = setting & (press[BtnMinuto] | rep[1]);
  assign accepted = modo_ev | hora_ev | min_ev;
  // A press on the final cycle counts as activity and cancels the timeout.
  assign timeout  = setting & ~accepted & (to_cnt_q >= ToLim);

  // ---------------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------------
`ifdef AUTO_REPETICION_EN
  localparam int unsigned HoldMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW      = $clog2(HoldMax + 1);

  localparam logic [HW-1:0] HoldLim = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] RepLim  = HW'(REPEAT_CYCLES);
  localparam logic [HW-1:0] HoldSat = HW'(HoldMax);
  localparam logic [HW-1:0] HoldOne = HW'(1);

  // hold_cnt_q counts cycles since the last pulse of that button (0 = idle);
  // rep_phase_q selects the initial hold delay or the repeat period.
  logic [HW-1:0] hold_cnt_q [2];
  logic [HW-1:0] hold_cnt_d [2];
  logic [1:0]    rep_phase_q, rep_phase_d;
  logic [1:0]    hold_lvl, hold_press;

  assign hold_lvl   = {deb_q[BtnMinuto], deb_q[BtnHora]};
  assign hold_press = {press[BtnMinuto], press[BtnHora]};

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      rep[j] = (hold_cnt_q[j] != '0) & hold_lvl[j] &
               (hold_cnt_q[j] == (rep_phase_q[j] ? RepLim : HoldLim));
    end
  end

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      hold_cnt_d[j]  = hold_cnt_q[j];
      rep_phase_d[j] = rep_phase_q[j];
      if ((state_d != state_q) || !hold_lvl[j]) begin
        hold_cnt_d[j]  = '0;
        rep_phase_d[j] = 1'b0;
      end else if (setting && hold_press[j]) begin
        hold_cnt_d[j]  = HoldOne;
        rep_phase_d[j] = 1'b0;
      end else if (rep[j]) begin
        hold_cnt_d[j]  = HoldOne;
        rep_phase_d[j] = 1'b1;
      end else if ((hold_cnt_q[j] != '0) && (hold_cnt_q[j] != HoldSat)) begin
        hold_cnt_d[j]  = hold_cnt_q[j] + HoldOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_phase_q <= '0;
      for (int j = 0; j < 2; j++) begin
        hold_cnt_q[j] <= '0;
      end
    end else begin
      rep_phase_q <= rep_phase_d;
      for (int j = 0; j < 2; j++) begin
        hold_cnt_q[j] <= hold_cnt_d[j];
      end
    end
  end
`else
  assign rep = 2'b00;
`endif

  // ---------------------------------------------------------------------------
  // Mode FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StNormal;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Mode FSM: next state and inactivity counter
  always_comb begin
    state_d = state_q;
    if (modo_ev) begin
      case (state_q)
        StNormal: state_d = StReloj;
        StReloj:  state_d = StAlarma;
        StAlarma: state_d = StNormal;
        default:  state_d = StNormal;
      endcase
    end else if (timeout) begin
      state_d = StNormal;
    end

    to_cnt_d = to_cnt_q;
    if (!setting || accepted || (state_d != state_q)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != ToMax) begin
      to_cnt_d = to_cnt_q + ToInc;
    end
  end

  // Mode FSM: outputs (next values; registered below)
  logic hora_reloj_d, minuto_reloj_d, hora_alarma_d, minuto_alarma_d;
  logic seleccion_d, ajustando_d, pausa_segundos_d;

  always_comb begin
    // A modo press wins over a coincident hour/minute event.
    hora_reloj_d     = (state_q == StReloj)  & hora_ev & ~modo_ev;
    minuto_reloj_d   = (state_q == StReloj)  & min_ev  & ~modo_ev;
    hora_alarma_d    = (state_q == StAlarma) & hora_ev & ~modo_ev;
    minuto_alarma_d  = (state_q == StAlarma) & min_ev  & ~modo_ev;
    seleccion_d      = (state_d == StAlarma);
    ajustando_d      = (state_d != StNormal);
    pausa_segundos_d = (state_d == StReloj);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hora_reloj     <= 1'b0;
      minuto_reloj   <= 1'b0;
      hora_alarma    <= 1'b0;
      minuto_alarma  <= 1'b0;
      seleccion      <= 1'b0;
      ajustando      <= 1'b0;
      pausa_segundos <= 1'b0;
    end else begin
      hora_reloj     <= hora_reloj_d;
      minuto_reloj   <= minuto_reloj_d;
      hora_alarma    <= hora_alarma_d;
      minuto_alarma  <= minuto_alarma_d;
      seleccion      <= seleccion_d;
      ajustando      <= ajustando_d;
      pausa_segundos <= pausa_segundos_d;
    end
  end

endmodule
